// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared single-port data memory.
// The host com port has absolute priority; cores share the remaining slots
// round-robin. One access issues per cycle on registered mem_* outputs, and a
// two-stage tag pipeline routes synchronous read data back to the requester.
module mem_port_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // Host com port
  input  logic                        com_req,
  input  logic                        com_wr_en,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic [DATA_W-1:0]           com_wdata,
  output logic                        com_grant,
  output logic                        com_rvalid,
  output logic [DATA_W-1:0]           com_rdata,
  // Core load/store ports
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  // Memory side
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_wr_en,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  // Status
  output logic                        idle
);

  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  // Unpacked views of the per-core buses
  logic [ADDR_W-1:0] core_addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] core_wdata_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign core_addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign core_wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  // Arbitration state and request selection
  ptr_t              rr_ptr_q, rr_ptr_d;
  ptr_t              win_idx;
  ptr_t              cand_p;
  int unsigned       cand;
  logic              core_hit;
  logic              xfer;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Registered memory command
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_en_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Read tag pipeline: stage 1 tracks the address cycle, stage 2 the data cycle
  logic tag1_valid_q, tag1_com_q;
  ptr_t tag1_id_q;
  logic tag2_valid_q, tag2_com_q;
  ptr_t tag2_id_q;

  assign com_grant = com_req;

  // Round-robin search starting at rr_ptr; suppressed entirely while com requests
  always_comb begin
    core_grant = '0;
    win_idx    = '0;
    core_hit   = 1'b0;
    cand       = 0;
    cand_p     = '0;
    if (!com_req) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= NUM_CORES) begin
          cand = cand - NUM_CORES;
        end
        cand_p = PtrW'(cand);
        if (!core_hit && core_req[cand_p]) begin
          core_hit           = 1'b1;
          win_idx            = cand_p;
          core_grant[cand_p] = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the winning core; com grants and idle cycles leave it alone
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (core_hit) begin
      rr_ptr_d = (win_idx == PtrW'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign xfer = com_req | core_hit;

  // Mux the winning requester's command fields
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (com_req) begin
      sel_wr    = com_wr_en;
      sel_addr  = com_addr;
      sel_wdata = com_wdata;
    end else if (core_hit) begin
      sel_wr    = core_wr_en[win_idx];
      sel_addr  = core_addr_arr[win_idx];
      sel_wdata = core_wdata_arr[win_idx];
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Memory command register; address and data hold when nothing transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_wr_en_q <= xfer & sel_wr;
      if (xfer) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
    end
  end

  // Tag pipeline; reset drops any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_valid_q <= 1'b0;
      tag1_com_q   <= 1'b0;
      tag1_id_q    <= '0;
      tag2_valid_q <= 1'b0;
      tag2_com_q   <= 1'b0;
      tag2_id_q    <= '0;
    end else begin
      tag1_valid_q <= xfer & ~sel_wr;
      tag1_com_q   <= com_req;
      tag1_id_q    <= win_idx;
      tag2_valid_q <= tag1_valid_q;
      tag2_com_q   <= tag1_com_q;
      tag2_id_q    <= tag1_id_q;
    end
  end

  // Return-path strobes decoded from the stage-2 tag
  always_comb begin
    core_rvalid = '0;
    if (tag2_valid_q && !tag2_com_q) begin
      core_rvalid[tag2_id_q] = 1'b1;
    end
  end

  assign com_rvalid = tag2_valid_q & tag2_com_q;
  assign com_rdata  = mem_rdata;
  assign core_rdata = mem_rdata;

  assign mem_addr  = mem_addr_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_wdata = mem_wdata_q;

  assign idle = ~com_req & ~|core_req & ~tag1_valid_q & ~tag2_valid_q;

endmodule
